// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding, word-length limits and
// the word-length clamp used wherever data_bits is latched.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 8;

  function automatic logic [3:0] clamp_data_bits(input logic [3:0] bits);
    if (bits < 4'(DATA_BITS_MIN)) begin
      return 4'(DATA_BITS_MIN);
    end else if (bits > 4'(DATA_BITS_MAX)) begin
      return 4'(DATA_BITS_MAX);
    end else begin
      return bits;
    end
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for asynchronous UART line inputs (rxd, CTS, DSR).
// Resets to 1 so an idle line never looks like a start bit out of reset.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive engine: oversampled start-bit validation, LSB-first data shift,
// parity and stop checks, and a one-cycle rx_valid pulse with error flags.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       rxd,
  input  logic [3:0] data_bits,
  input  logic       parity_en,
  input  logic       parity_even,
  input  logic [1:0] stop_bits,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       framing_err,
  output logic       break_det,
  output logic       busy,
  output rx_state_t  dbg_state
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] TICK_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);

  rx_state_t     r_state;
  rx_state_t     w_state_next;
  logic [CW-1:0] r_tick;
  logic [2:0]    r_bitcnt;
  logic          r_stopcnt;
  logic [7:0]    r_shreg;
  logic          r_par_bit;
  logic          r_ferr_acc;
  logic [3:0]    r_nbits;
  logic          r_par_en;
  logic          r_par_even;
  logic          r_two_stop;
  logic [7:0]    r_rx_data;
  logic          r_rx_valid;
  logic          r_perr;
  logic          r_ferr;
  logic          r_brk;

  logic          w_rxd_s;
  logic          w_mid;
  logic          w_centre;
  logic [2:0]    w_last_bit;
  logic          w_last_stop;
  logic          w_ferr_final;
  logic          w_frame_done;
  logic [7:0]    w_data_aligned;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_d     (rxd),
    .o_q     (w_rxd_s)
  );

  assign w_mid          = baud_tick && (r_tick == TICK_MID);
  assign w_centre       = baud_tick && (r_tick == TICK_LAST);
  assign w_last_bit     = 3'(r_nbits - 4'd1);
  assign w_last_stop    = (r_stopcnt == r_two_stop);
  assign w_ferr_final   = r_ferr_acc | ~w_rxd_s;
  // Bits entered at the MSB end, so short words must be slid down to bit 0.
  assign w_data_aligned = r_shreg >> (4'd8 - r_nbits);

  always_comb begin
    w_state_next = r_state;
    w_frame_done = 1'b0;
    unique case (r_state)
      IDLE:      if (baud_tick && !w_rxd_s) w_state_next = START;
      START:     if (w_mid) w_state_next = w_rxd_s ? IDLE : DATA;
      DATA:      if (w_centre && (r_bitcnt == w_last_bit))
                   w_state_next = r_par_en ? PARITY : STOP;
      PARITY:    if (w_centre) w_state_next = STOP;
      STOP: begin
        if (w_centre && w_last_stop) begin
          w_frame_done = 1'b1;
          w_state_next = w_ferr_final ? WAIT_IDLE : IDLE;
        end
      end
      WAIT_IDLE: if (baud_tick && w_rxd_s) w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_tick     <= '0;
      r_bitcnt   <= '0;
      r_stopcnt  <= 1'b0;
      r_shreg    <= '0;
      r_par_bit  <= 1'b0;
      r_ferr_acc <= 1'b0;
      r_nbits    <= 4'd8;
      r_par_en   <= 1'b0;
      r_par_even <= 1'b0;
      r_two_stop <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_brk      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_rx_valid <= 1'b0;
      // The counter restarts on every state change so each sample lands on a bit centre.
      if (w_state_next != r_state) begin
        r_tick <= '0;
      end else if (baud_tick) begin
        r_tick <= (r_tick == TICK_LAST) ? '0 : r_tick + 1'b1;
      end
      unique case (r_state)
        IDLE: begin
          if (w_state_next == START) begin
            r_nbits    <= clamp_data_bits(data_bits);
            r_par_en   <= parity_en;
            r_par_even <= parity_even;
            r_two_stop <= (stop_bits >= 2'd2);
            r_bitcnt   <= '0;
            r_stopcnt  <= 1'b0;
            r_ferr_acc <= 1'b0;
            r_par_bit  <= 1'b0;
          end
        end
        DATA: begin
          if (w_centre) begin
            r_shreg  <= {w_rxd_s, r_shreg[7:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
          end
        end
        PARITY: begin
          if (w_centre) r_par_bit <= w_rxd_s;
        end
        STOP: begin
          if (w_centre) begin
            r_ferr_acc <= w_ferr_final;
            r_stopcnt  <= 1'b1;
            if (w_frame_done) begin
              r_rx_data  <= w_data_aligned;
              r_rx_valid <= 1'b1;
              r_perr     <= r_par_en & (^w_data_aligned ^ r_par_bit ^ ~r_par_even);
              r_ferr     <= w_ferr_final;
              r_brk      <= w_ferr_final && (w_data_aligned == 8'd0) &&
                            (!r_par_en || !r_par_bit);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign parity_err  = r_perr;
  assign framing_err = r_ferr;
  assign break_det   = r_brk;
  assign busy        = (r_state != IDLE);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: serial line model, directed frame scenarios,
// randomized frames with baud_tick stalls, and a queue-based scoreboard.
module tb_uart_rx_deserializer;
  import uart_pkg::*;

  localparam int OS = 16;
  localparam int W  = 11;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rxd = 1'b1;
  logic [3:0] data_bits = 4'd8;
  logic       parity_en = 1'b0;
  logic       parity_even = 1'b0;
  logic [1:0] stop_bits = 2'd1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       framing_err;
  logic       break_det;
  logic       busy;
  rx_state_t  dbg_state;

  logic       stall_en = 1'b0;
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  uart_rx_deserializer #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_tick   (baud_tick),
    .rxd         (rxd),
    .data_bits   (data_bits),
    .parity_en   (parity_en),
    .parity_even (parity_even),
    .stop_bits   (stop_bits),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .parity_err  (parity_err),
    .framing_err (framing_err),
    .break_det   (break_det),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // clock and baud tick generation
  always #5 clk = ~clk;

  initial begin
    int gap;
    forever begin
      gap = 4;
      if (stall_en && ($urandom_range(0, 7) == 0)) gap += $urandom_range(1, 20);
      repeat (gap - 1) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!baud_tick) @(posedge clk);
    end
  endtask

  task automatic drive_bit(input logic b, input int nticks);
    @(negedge clk);
    rxd = b;
    wait_ticks(nticks);
  endtask

  task automatic idle_bits(input int n);
    drive_bit(1'b1, OS * n);
  endtask

  task automatic send_frame(input logic [7:0] data, input int nb_raw, input logic pen,
                            input logic peven, input logic flip, input int sb_raw,
                            input logic [1:0] stop_mask, input logic scramble);
    int nb, ns, ones;
    logic [7:0] masked;
    logic p, perr, ferr, brk;
    nb = (nb_raw < 5) ? 5 : ((nb_raw > 8) ? 8 : nb_raw);
    ns = (sb_raw >= 2) ? 2 : 1;
    data_bits   = 4'(nb_raw);
    parity_en   = pen;
    parity_even = peven;
    stop_bits   = 2'(sb_raw);
    masked = 8'((32'(data) & ((32'd1 << nb) - 1)));
    ones   = $countones(masked);
    p      = peven ? (ones % 2 == 1) : (ones % 2 == 0);
    if (flip) p = !p;
    ferr = 1'b0;
    for (int s = 0; s < ns; s++) if (!stop_mask[s]) ferr = 1'b1;
    perr = pen && (((ones + int'(p)) % 2) != (peven ? 0 : 1));
    brk  = ferr && (masked == 8'd0) && (!pen || !p);
    exp_q.push_back({masked, perr, ferr, brk});
    drive_bit(1'b0, OS);
    if (scramble) begin
      data_bits   = 4'($urandom_range(0, 15));
      parity_en   = 1'($urandom_range(0, 1));
      parity_even = 1'($urandom_range(0, 1));
      stop_bits   = 2'($urandom_range(0, 3));
    end
    for (int i = 0; i < nb; i++) drive_bit(data[i], OS);
    if (pen) drive_bit(p, OS);
    for (int s = 0; s < ns; s++) drive_bit(stop_mask[s], OS);
  endtask

  // scoreboard monitor
  task automatic monitor();
    logic [W-1:0] act, exp;
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        act = {rx_data, parity_err, framing_err, break_det};
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_frame: got data=0x%02h pe=%0b fe=%0b bk=%0b, expected no rx_valid",
                   act[10:3], act[2], act[1], act[0]);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin
            n_err++;
            $display("FAIL frame: got data=0x%02h pe=%0b fe=%0b bk=%0b, expected data=0x%02h pe=%0b fe=%0b bk=%0b",
                     act[10:3], act[2], act[1], act[0], exp[10:3], exp[2], exp[1], exp[0]);
          end
        end
      end
    end
  endtask

  initial begin
    int t;
    fork
      monitor();
    join_none

    // reset state
    repeat (5) @(negedge clk);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_flags", {parity_err, framing_err, break_det}, 3'b000);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b1;
    idle_bits(2);

    // 8N1 0xA5
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1, 2'b11, 1'b0);
    idle_bits(2);

    // 8E1 with wrong parity, then 8O1 with correct parity
    send_frame(8'h3C, 8, 1'b1, 1'b1, 1'b1, 1, 2'b11, 1'b0);
    idle_bits(1);
    send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b0, 1, 2'b11, 1'b0);
    idle_bits(2);

    // 5N2, second stop low, line stays low for a while
    send_frame(8'h15, 5, 1'b0, 1'b0, 1'b0, 2, 2'b01, 1'b0);
    drive_bit(1'b0, OS * 3);
    check("wait_idle_busy", busy, 1'b1);
    idle_bits(2);
    check("wait_idle_exit", busy, 1'b0);

    // line break: 40 bit periods low
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1, 2'b00, 1'b0);
    drive_bit(1'b0, OS * 30);
    check("break_busy", busy, 1'b1);
    idle_bits(2);
    check("break_exit", busy, 1'b0);

    // short glitch: false start
    @(negedge clk);
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_busy", busy, 1'b1);
    rxd = 1'b1;
    idle_bits(2);
    check("glitch_idle", busy, 1'b0);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1, 2'b11, 1'b0);
    idle_bits(2);

    // reset mid-frame
    data_bits = 4'd8; parity_en = 1'b0; stop_bits = 2'd1;
    drive_bit(1'b0, OS);
    drive_bit(1'b1, OS * 3);
    check("abort_busy", busy, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_rx_data", rx_data, 8'h00);
    check("abort_busy_clr", busy, 1'b0);
    rst = 1'b1;
    idle_bits(2);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1, 2'b11, 1'b0);
    idle_bits(2);

    // randomized frames with baud_tick stalls and config scrambling mid-frame
    stall_en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 15),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11, 1'b1);
      idle_bits($urandom_range(1, 2));
    end
    stall_en = 1'b0;

    // drain and report
    t = 0;
    while ((t < 2000) && (exp_q.size() != 0)) begin
      @(negedge clk);
      t++;
    end
    check("pending_frames", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
